line_buffer_3row: RTL and testbench
===================================

LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (legal range 4..2048).
REQ-002 Parameter DATA_W, default 8, pixel width in bits.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-high reset.
REQ-005 Port din, input, DATA_W, incoming raster pixel.
REQ-006 Port din_valid, input, 1, din is valid this cycle (pixel accepted).
REQ-007 Port sof, input, 1, start of frame; qualified by din_valid, marks the first pixel of a frame.
REQ-008 Port row0, output, DATA_W, current-line pixel (registered copy of din).
REQ-009 Port row1, output, DATA_W, same column, one line earlier.
REQ-010 Port row2, output, DATA_W, same column, two lines earlier.
REQ-011 Port dout_valid, output, 1, row0..row2 form a vertically aligned 3-pixel column.
REQ-012 Port eol, output, 1, one-cycle pulse coincident with output of column IMG_WIDTH-1.

Function
REQ-013 Block SHALL keep two line memories, LB1 (previous line) and LB2 (line before that), each IMG_WIDTH x DATA_W.
REQ-014 Column counter col SHALL address both memories; it SHALL advance by 1 per accepted pixel and wrap from IMG_WIDTH-1 to 0.
REQ-015 On accepted pixel at col=c: row0<=din, row1<=LB1[c], row2<=LB2[c], LB1[c]<=din, LB2[c]<=old LB1[c] (read-before-write, same cycle).
REQ-016 Latency SHALL be exactly 1 clock from accepted din to row0..row2/dout_valid.
REQ-017 Row counter row_cnt (0..2) SHALL increment on each col wrap and saturate at 2.
REQ-018 dout_valid SHALL be 1 one cycle after an accepted pixel only when row_cnt==2 at acceptance; otherwise 0.
REQ-019 eol SHALL pulse with the output of column IMG_WIDTH-1 whenever dout_valid would pulse for that pixel.
REQ-020 din_valid=0 cycles SHALL hold col, row_cnt, memories and row0..row2; dout_valid and eol SHALL be 0.
REQ-021 sof with din_valid SHALL force that pixel to col=0, row_cnt=0; it is processed as column 0 of the first line, so dout_valid stays 0 for two full lines.
REQ-022 sof arriving mid-line SHALL abandon the partial line; no error flag.
REQ-023 sof without din_valid SHALL be ignored.
REQ-024 Memory contents SHALL not be cleared by reset or sof; stale data never reaches a dout_valid=1 output because of REQ-018/REQ-021.

Reset
REQ-025 rst=1 SHALL asynchronously set col=0, row_cnt=0, row0=row1=row2=0, dout_valid=0, eol=0 (no high-impedance values).
REQ-026 Reset asserted mid-line SHALL behave as REQ-021 after release: first two lines after reset produce no dout_valid.
REQ-027 First rising edge after rst deasserts SHALL accept din normally.

Structure
REQ-028 Shared package SHALL hold DATA_W default, IMG_WIDTH default, and COL_W = clog2(IMG_WIDTH) constant.
REQ-029 One sub-module line_ram (single-clock, one read + one write port, same-address read-old-data) SHALL be instantiated twice, for LB1 and LB2.
REQ-030 Outputs SHALL be suitable to drive three shift_register-style 3-tap stages (row0, row1, row2) directly to form a 3x3 window.

Verification (IMG_WIDTH=4)
REQ-031 Reset, then sof+pixels 1..12 continuous -> dout_valid=0 for pixels 1..8; pixels 9..12 give (row0,row1,row2)=(9,5,1),(10,6,2),(11,7,3),(12,8,4), eol with 12.
REQ-032 Same stream with din_valid low every other cycle -> identical output tuples, dout_valid only 1 cycle after each accepted pixel, outputs held between.
REQ-033 Continue to pixels 13..16 -> (13,9,5)..(16,12,8); row_cnt stays saturated.
REQ-034 sof at pixel 14 (mid-line) -> no dout_valid until 8 further accepted pixels; next valid tuple uses only post-sof data.
REQ-035 rst pulse asynchronously between clock edges mid-line -> all outputs 0 immediately; stream restart behaves as REQ-031.
REQ-036 sof with din_valid=0 -> no counter change; subsequent pixels continue existing line.

Source files
------------

// File: rtl/line_buffer_3row_pkg.sv
// Shared constants and types for the three-row line buffer.
package line_buffer_3row_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int IMG_WIDTH_DEF = 640;
    localparam int COL_W         = $clog2(IMG_WIDTH_DEF);

    // Number of complete lines seen since frame start, saturating at two.
    typedef enum logic [1:0] {
        ROW_0 = 2'd0,
        ROW_1 = 2'd1,
        ROW_2 = 2'd2
    } row_state_t;

    function automatic row_state_t row_advance(input row_state_t r);
        case (r)
            ROW_0:   return ROW_1;
            default: return ROW_2;
        endcase
    endfunction

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, vertically aligned 3-pixel column out.
interface line_buffer_3row_if
    import line_buffer_3row_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    // A pixel moves when din_valid is high on a rising edge; there is no
    // backpressure. dout_valid marks a cycle where row0..row2 are one column.
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              sof;
    logic [DATA_W-1:0] row0;
    logic [DATA_W-1:0] row1;
    logic [DATA_W-1:0] row2;
    logic              dout_valid;
    logic              eol;
    row_state_t        dbg_row_state;

    modport master (
        output din, din_valid, sof,
        input  row0, row1, row2, dout_valid, eol, dbg_row_state
    );

    modport slave (
        input  din, din_valid, sof,
        output row0, row1, row2, dout_valid, eol, dbg_row_state
    );

endinterface

// File: rtl/line_buffer_3row_line_ram.sv
// One line of pixel storage: synchronous write, asynchronous read (old data on same address).
module line_ram #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/line_buffer_3row.sv
// Two line memories chained so each accepted pixel emits its column from the last three lines.
module line_buffer_3row
    import line_buffer_3row_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst,
    line_buffer_3row_if.slave bus
);

    localparam int              CW       = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0]   LAST_COL = CW'(IMG_WIDTH - 1);

    logic [CW-1:0]     col_q, col_d, col_eff;
    row_state_t        row_q, row_d, row_eff;
    logic [DATA_W-1:0] row0_q, row0_d, row1_q, row1_d, row2_q, row2_d;
    logic              valid_q, valid_d, eol_q, eol_d;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;

    // sof restarts the frame on the very pixel it qualifies.
    always_comb begin
        col_eff = bus.sof ? '0 : col_q;
        row_eff = bus.sof ? ROW_0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        row0_d  = row0_q;
        row1_d  = row1_q;
        row2_d  = row2_q;
        valid_d = 1'b0;
        eol_d   = 1'b0;
        if (bus.din_valid) begin
            row0_d  = bus.din;
            row1_d  = lb1_rd;
            row2_d  = lb2_rd;
            valid_d = (row_eff == ROW_2);
            eol_d   = (row_eff == ROW_2) && (col_eff == LAST_COL);
            if (col_eff == LAST_COL) begin
                col_d = '0;
                row_d = row_advance(row_eff);
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= ROW_0;
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
            valid_q <= valid_d;
            eol_q   <= eol_d;
        end
    end

    // LB2 takes the value LB1 held before this edge, shifting the column down a line.
    line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb1 (
        .clk   (clk),
        .we    (bus.din_valid),
        .waddr (col_eff),
        .wdata (bus.din),
        .raddr (col_eff),
        .rdata (lb1_rd)
    );

    line_ram #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W), .ADDR_W(CW)) u_lb2 (
        .clk   (clk),
        .we    (bus.din_valid),
        .waddr (col_eff),
        .wdata (lb1_rd),
        .raddr (col_eff),
        .rdata (lb2_rd)
    );

    assign bus.row0          = row0_q;
    assign bus.row1          = row1_q;
    assign bus.row2          = row2_q;
    assign bus.dout_valid    = valid_q;
    assign bus.eol           = eol_q;
    assign bus.dbg_row_state = row_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed and random pixel streams against a frame-image reference model.
module tb_line_buffer_3row;
    import line_buffer_3row_pkg::*;

    localparam int W  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_buffer_3row_if #(.DATA_W(DW)) bus ();

    line_buffer_3row #(.IMG_WIDTH(W), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    // Reference: the frame as an image, indexed by line-within-frame and column.
    logic [DW-1:0] img [64][W];
    int            m_line, m_col;
    logic [DW-1:0] e_r0, e_r1, e_r2;
    logic          e_valid, e_eol;
    bit            e_rows_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_line       = 0;
        m_col        = 0;
        e_r0         = '0;
        e_r1         = '0;
        e_r2         = '0;
        e_valid      = 1'b0;
        e_eol        = 1'b0;
        e_rows_known = 1'b1;
    endtask

    task automatic check_outputs();
        chk("dout_valid", 32'(bus.dout_valid), 32'(e_valid));
        chk("eol", 32'(bus.eol), 32'(e_eol));
        chk("row0", 32'(bus.row0), 32'(e_r0));
        if (e_rows_known) begin
            chk("row1", 32'(bus.row1), 32'(e_r1));
            chk("row2", 32'(bus.row2), 32'(e_r2));
        end
        chk("row_cnt", 32'(bus.dbg_row_state), (m_line > 2) ? 32'd2 : 32'(m_line));
    endtask

    // Drive one cycle from a negedge, update the model, check at the next negedge.
    task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
        step_no++;
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = d;
        if (v) begin
            if (s) begin
                m_line = 0;
                m_col  = 0;
            end
            img[m_line % 64][m_col] = d;
            e_valid = (m_line >= 2);
            e_r0    = d;
            if (e_valid) begin
                e_r1 = img[(m_line - 1) % 64][m_col];
                e_r2 = img[(m_line - 2) % 64][m_col];
            end
            e_rows_known = e_valid;
            e_eol        = e_valid && (m_col == W - 1);
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_line++;
            end
        end else begin
            e_valid = 1'b0;
            e_eol   = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic chk_tuple(input string tag, input int a, input int b, input int c);
        chk(tag, {8'h00, bus.row0, bus.row1, bus.row2}, {8'h00, 8'(a), 8'(b), 8'(c)});
    endtask

    initial begin
        bit v, s;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();

        // Continuous frame start: two silent lines, then aligned columns.
        for (int p = 1; p <= 12; p++) begin
            step(1'b1, p == 1, 8'(p));
            if (p >= 9) chk_tuple("cont_tuple", p, p - 4, p - 8);
        end
        chk("cont_eol12", 32'(bus.eol), 32'd1);
        for (int p = 13; p <= 16; p++) begin
            step(1'b1, 1'b0, 8'(p));
            chk_tuple("sat_tuple", p, p - 4, p - 8);
        end
        chk("sat_row_cnt", 32'(bus.dbg_row_state), 32'd2);

        // Same frame with an idle cycle after every pixel.
        for (int p = 1; p <= 12; p++) begin
            step(1'b1, p == 1, 8'(p));
            if (p >= 9) chk_tuple("gap_tuple", p, p - 4, p - 8);
            step(1'b0, 1'b0, 8'hAA);
            if (p >= 9) chk_tuple("gap_hold", p, p - 4, p - 8);
        end

        // Mid-line sof abandons the partial line.
        step(1'b1, 1'b0, 8'd13);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, k == 0, 8'(14 + k));
            if (k < 8) chk("sof_mid_quiet", 32'(bus.dout_valid), 32'd0);
            if (k == 8) chk_tuple("sof_mid_first", 22, 18, 14);
        end

        // sof without din_valid must not disturb the line in progress.
        step(1'b0, 1'b1, 8'd77);
        step(1'b1, 1'b0, 8'd200);
        chk_tuple("sof_novalid", 200, 20, 16);

        // Random traffic with occasional frame restarts.
        repeat (300) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 39) == 0);
            step(v, s, 8'($urandom_range(0, 255)));
        end

        // Asynchronous reset between edges, mid-line.
        step(1'b1, 1'b0, 8'h5A);
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_tuple("arst_rows", 0, 0, 0);
        chk("arst_valid", 32'(bus.dout_valid), 32'd0);
        chk("arst_eol", 32'(bus.eol), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
        for (int p = 1; p <= 12; p++) begin
            step(1'b1, p == 1, 8'(p));
            if (p >= 9) chk_tuple("rst_replay", p, p - 4, p - 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
